// File: rtl/mac_learn_table.sv
// MAC learning table: learns source MACs per one-hot port, answers destination lookups with a forwarding mask.
// Latency: a learn spends 3 cycles (IDLE/CMP/WRITE); a lookup result appears exactly 2 cycles after lkp_valid.
// Backpressure: lrn_ready is high only in IDLE; lookups are never stalled. Optional aging via `define MAC_AGING_EN.
module mac_learn_table #(
    parameter int PORT_NUMBER = 4,
    parameter int TABLE_DEPTH = 16,
    parameter int AGE_PERIOD  = 1000000,
    parameter int AGE_MAX     = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           lrn_valid,
    output logic                           lrn_ready,
    input  logic [47:0]                    lrn_mac,
    input  logic [PORT_NUMBER-1:0]         lrn_port,
    input  logic                           lkp_valid,
    input  logic [47:0]                    lkp_mac,
    input  logic [PORT_NUMBER-1:0]         lkp_src_port,
    output logic                           res_valid,
    output logic                           res_hit,
    output logic [PORT_NUMBER-1:0]         res_port_mask,
    output logic [$clog2(TABLE_DEPTH+1)-1:0] entry_count,
    output logic                           table_full,
    output logic                           lrn_drop
);

    localparam int IDX_W = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
    localparam int CNT_W = $clog2(TABLE_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMP   = 2'd1,
        WRITE = 2'd2
    } lrn_state_t;

    lrn_state_t state, state_nxt;

    // Table storage: only the valid bits (and ages) need reset; mac/port are qualified by valid.
    logic [TABLE_DEPTH-1:0] ent_valid;
    logic [47:0]            ent_mac  [TABLE_DEPTH];
    logic [PORT_NUMBER-1:0] ent_port [TABLE_DEPTH];

    // Registered learn request and compare results.
    logic [47:0]            lrn_mac_q;
    logic [PORT_NUMBER-1:0] lrn_port_q;
    logic                   cmp_hit_q, cmp_free_q;
    logic [IDX_W-1:0]       cmp_hit_idx_q, cmp_free_idx_q;

    logic                   cmp_hit_c, cmp_free_c;
    logic [IDX_W-1:0]       cmp_hit_idx_c, cmp_free_idx_c;

    logic                   wr_en;
    logic [IDX_W-1:0]       wr_idx;
    logic                   lrn_accept;

    // Multicast/broadcast sources are never learned, so they are simply not accepted into CMP.
    assign lrn_accept = lrn_valid && !lrn_mac[40];

    // Parallel compare of the registered MAC; descending scan so the lowest index wins.
    always_comb begin
        cmp_hit_c      = 1'b0;
        cmp_free_c     = 1'b0;
        cmp_hit_idx_c  = '0;
        cmp_free_idx_c = '0;
        for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_mac[i] == lrn_mac_q)) begin
                cmp_hit_c     = 1'b1;
                cmp_hit_idx_c = IDX_W'(i);
            end
            if (!ent_valid[i]) begin
                cmp_free_c     = 1'b1;
                cmp_free_idx_c = IDX_W'(i);
            end
        end
    end

    // Learn FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Learn FSM next state, handshake and write decision.
    always_comb begin
        state_nxt = state;
        lrn_ready = 1'b0;
        lrn_drop  = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        case (state)
            IDLE: begin
                lrn_ready = 1'b1;
                if (lrn_accept) begin
                    state_nxt = CMP;
                end
            end
            CMP: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                state_nxt = IDLE;
                if (cmp_hit_q) begin
                    wr_en  = 1'b1;
                    wr_idx = cmp_hit_idx_q;
                end else if (cmp_free_q) begin
                    wr_en  = 1'b1;
                    wr_idx = cmp_free_idx_q;
                end else begin
                    lrn_drop = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the learn request in IDLE and the compare outcome in CMP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lrn_mac_q      <= '0;
            lrn_port_q     <= '0;
            cmp_hit_q      <= 1'b0;
            cmp_free_q     <= 1'b0;
            cmp_hit_idx_q  <= '0;
            cmp_free_idx_q <= '0;
        end else begin
            if (state == IDLE && lrn_accept) begin
                lrn_mac_q  <= lrn_mac;
                lrn_port_q <= lrn_port;
            end
            if (state == CMP) begin
                cmp_hit_q      <= cmp_hit_c;
                cmp_free_q     <= cmp_free_c;
                cmp_hit_idx_q  <= cmp_hit_idx_c;
                cmp_free_idx_q <= cmp_free_idx_c;
            end
        end
    end

    // Entry payload write; a refresh rewrites the same MAC with the new port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ent_mac[wr_idx]  <= lrn_mac_q;
            ent_port[wr_idx] <= lrn_port_q;
        end
    end

`ifdef MAC_AGING_EN
    localparam int AGE_W = $clog2(AGE_MAX + 1);
    localparam int PRE_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;

    logic [PRE_W-1:0] presc;
    logic             age_tick;
    logic [AGE_W-1:0] ent_age [TABLE_DEPTH];

    assign age_tick = (presc == PRE_W'(AGE_PERIOD - 1));

    // Aging prescaler: wraps every AGE_PERIOD cycles, tick on the wrap cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (age_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Valid/age update: a write wins over a same-cycle tick; reaching AGE_MAX expires the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                ent_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    ent_valid[i] <= 1'b1;
                    ent_age[i]   <= '0;
                end else if (age_tick && ent_valid[i]) begin
                    if (ent_age[i] >= AGE_W'(AGE_MAX - 1)) begin
                        ent_valid[i] <= 1'b0;
                        ent_age[i]   <= '0;
                    end else begin
                        ent_age[i] <= ent_age[i] + 1'b1;
                    end
                end
            end
        end
    end
`else
    // Valid update: entries are only ever set by a learn write and never expire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
        end else begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    ent_valid[i] <= 1'b1;
                end
            end
        end
    end
`endif

    // Occupancy is the population count of valid bits, so simultaneous allocate/expire nets out.
    always_comb begin
        entry_count = '0;
        for (int i = 0; i < TABLE_DEPTH; i++) begin
            entry_count = entry_count + CNT_W'(ent_valid[i]);
        end
    end

    assign table_full = (entry_count == CNT_W'(TABLE_DEPTH));

    // Lookup stage 1 match: table as it stands this cycle, lowest-index hit.
    logic                   lk_hit_c;
    logic [PORT_NUMBER-1:0] lk_port_c;

    always_comb begin
        lk_hit_c  = 1'b0;
        lk_port_c = '0;
        for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_mac[i] == lkp_mac)) begin
                lk_hit_c  = 1'b1;
                lk_port_c = ent_port[i];
            end
        end
    end

    logic                   s1_vld, s1_hit;
    logic [PORT_NUMBER-1:0] s1_port, s1_src;

    // Lookup stage 1 register: group addresses are forced to miss (flood).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_hit  <= 1'b0;
            s1_port <= '0;
            s1_src  <= '0;
        end else begin
            s1_vld  <= lkp_valid;
            s1_hit  <= lkp_valid && !lkp_mac[40] && lk_hit_c;
            s1_port <= lk_port_c;
            s1_src  <= lkp_src_port;
        end
    end

    // Lookup stage 2: forwarding mask excludes the ingress port; outputs are zero when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid     <= 1'b0;
            res_hit       <= 1'b0;
            res_port_mask <= '0;
        end else begin
            res_valid <= s1_vld;
            res_hit   <= s1_vld && s1_hit;
            if (!s1_vld) begin
                res_port_mask <= '0;
            end else if (s1_hit) begin
                res_port_mask <= s1_port & ~s1_src;
            end else begin
                res_port_mask <= ~s1_src;
            end
        end
    end

endmodule

// File: tb/tb_mac_learn_table.sv
module tb_mac_learn_table;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lrn_valid = 1'b0;
    logic        lrn_ready;
    logic [47:0] lrn_mac = '0;
    logic [3:0]  lrn_port = '0;
    logic        lkp_valid = 1'b0;
    logic [47:0] lkp_mac = '0;
    logic [3:0]  lkp_src_port = '0;
    logic        res_valid, res_hit;
    logic [3:0]  res_port_mask;
    logic [4:0]  entry_count;
    logic        table_full, lrn_drop;

    mac_learn_table #(
        .PORT_NUMBER(4), .TABLE_DEPTH(16), .AGE_PERIOD(10), .AGE_MAX(3)
    ) dut (
        .clk(clk), .rst(rst),
        .lrn_valid(lrn_valid), .lrn_ready(lrn_ready), .lrn_mac(lrn_mac), .lrn_port(lrn_port),
        .lkp_valid(lkp_valid), .lkp_mac(lkp_mac), .lkp_src_port(lkp_src_port),
        .res_valid(res_valid), .res_hit(res_hit), .res_port_mask(res_port_mask),
        .entry_count(entry_count), .table_full(table_full), .lrn_drop(lrn_drop)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int drop_seen = 0;
    int drop_exp = 0;

    // Reference model: MAC -> port, bounded capacity, group MACs ignored.
    logic [3:0] mdl [logic [47:0]];

    always @(negedge clk) if (lrn_drop === 1'b1) drop_seen++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void mdl_learn(input logic [47:0] mac, input logic [3:0] port);
        if (mac[40]) return;
        if (mdl.exists(mac)) mdl[mac] = port;
        else if (mdl.num() < 16) mdl[mac] = port;
        else drop_exp++;
    endfunction

    function automatic void mdl_lookup(input logic [47:0] mac, input logic [3:0] src,
                                       output logic hit, output logic [3:0] mask);
        if (!mac[40] && mdl.exists(mac)) begin
            hit  = 1'b1;
            mask = mdl[mac] & ~src;
        end else begin
            hit  = 1'b0;
            mask = ~src;
        end
    endfunction

    task automatic do_reset();
        lrn_valid = 1'b0;
        lkp_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mdl.delete();
        @(negedge clk);
    endtask

    task automatic learn(input logic [47:0] mac, input logic [3:0] port);
        int n = 0;
        while (lrn_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (lrn_ready !== 1'b1) begin
            chk_cnt++;
            $display("FAIL learn_wait: lrn_ready=%b expected 1", lrn_ready);
        end
        lrn_valid = 1'b1;
        lrn_mac   = mac;
        lrn_port  = port;
        @(negedge clk);
        lrn_valid = 1'b0;
        repeat (2) @(negedge clk);
        mdl_learn(mac, port);
    endtask

    task automatic lookup(input string name, input logic [47:0] mac, input logic [3:0] src,
                          input logic exp_hit, input logic [3:0] exp_mask);
        lkp_valid    = 1'b1;
        lkp_mac      = mac;
        lkp_src_port = src;
        @(negedge clk);
        lkp_valid = 1'b0;
        check({name, "_early_valid"}, res_valid, 0);
        @(negedge clk);
        check({name, "_valid"}, res_valid, 1);
        check({name, "_hit"}, res_hit, exp_hit);
        check({name, "_mask"}, res_port_mask, exp_mask);
    endtask

    typedef struct {
        logic [47:0] mac;
        logic [3:0]  src;
        logic        hit;
        logic [3:0]  mask;
    } vec_t;

    vec_t vecs[6];
    logic [47:0] pool[24];
    localparam logic [47:0] MAC_A = 48'h0000_AA00_0001;

    initial begin
        logic       eh;
        logic [3:0] em;
        logic       p1_v, p2_v, p1_h, p2_h;
        logic [3:0] p1_m, p2_m;
        int         d0;

        vecs[0] = '{48'h0011_2233_4455, 4'b0001, 1'b1, 4'b0010};
        vecs[1] = '{48'hFFFF_FFFF_FFFF, 4'b0100, 1'b0, 4'b1011};
        vecs[2] = '{48'h00DE_ADBE_EF00, 4'b0100, 1'b0, 4'b1011};
        vecs[3] = '{MAC_A,              4'b0001, 1'b1, 4'b1000};
        vecs[4] = '{MAC_A,              4'b1000, 1'b1, 4'b0000};
        vecs[5] = '{48'h0100_0000_0001, 4'b0001, 1'b0, 4'b1110};

        // Asynchronous reset, checked before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_hit", res_hit, 0);
        check("rst_res_mask", res_port_mask, 0);
        check("rst_lrn_drop", lrn_drop, 0);
        check("rst_table_full", table_full, 0);
        check("rst_lrn_ready", lrn_ready, 1);
        check("rst_entry_count", entry_count, 0);
        @(negedge clk);
        do_reset();

        // Directed learns and the lookup vector table.
        learn(48'h0011_2233_4455, 4'b0010);
        learn(MAC_A, 4'b0001);
        learn(MAC_A, 4'b1000);
        learn(48'h0300_0000_0007, 4'b0100);
        check("dir_entry_count", entry_count, 2);
        foreach (vecs[i]) lookup($sformatf("vec%0d", i), vecs[i].mac, vecs[i].src, vecs[i].hit, vecs[i].mask);

        // Fill the table, then overflow with a 17th MAC.
        do_reset();
        d0 = drop_seen;
        for (int i = 0; i < 16; i++) learn({40'h00_0010_0000, 8'(i)}, 4'b0001 << (i % 4));
        check("full_count16", entry_count, 16);
        check("full_flag16", table_full, 1);
        check("full_no_drop", drop_seen - d0, 0);
        learn(48'h0000_1000_0099, 4'b0001);
        check("full_drop_once", drop_seen - d0, 1);
        check("full_count17", entry_count, 16);
        check("full_flag17", table_full, 1);
        lookup("full_17th_miss", 48'h0000_1000_0099, 4'b0010, 1'b0, 4'b1101);
        lookup("full_0th_hit", 48'h0000_1000_0000, 4'b0010, 1'b1, 4'b0001);

        // Random learns against the model, then a random back-to-back lookup stream.
        do_reset();
        for (int i = 0; i < 24; i++)
            pool[i] = {(i >= 20) ? 8'h03 : 8'h00, 32'($urandom) & 32'hFFFF_FF00, 8'(i)};
        d0 = drop_seen;
        drop_exp = 0;
        for (int i = 0; i < 40; i++)
            learn(pool[$urandom_range(0, 23)], 4'b0001 << $urandom_range(0, 3));
        check("rnd_entry_count", entry_count, 64'(mdl.num()));
        check("rnd_drops", drop_seen - d0, drop_exp);
        check("rnd_full", table_full, (mdl.num() == 16) ? 1 : 0);
        p1_v = 0; p2_v = 0; p1_h = 0; p2_h = 0; p1_m = 0; p2_m = 0;
        for (int c = 0; c < 302; c++) begin
            logic [47:0] m;
            logic [3:0]  s;
            logic        v;
            int          k;
            check("rnd_valid", res_valid, p2_v);
            check("rnd_hit", res_hit, p2_v ? p2_h : 1'b0);
            check("rnd_mask", res_port_mask, p2_v ? p2_m : 4'b0000);
            v = (c < 300) && ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 27);
            m = (k < 24) ? pool[k] : (k == 27) ? 48'hFFFF_FFFF_FFFF : {16'h0000, 32'($urandom)};
            s = 4'b0001 << $urandom_range(0, 3);
            mdl_lookup(m, s, eh, em);
            p2_v = p1_v; p2_h = p1_h; p2_m = p1_m;
            p1_v = v;    p1_h = eh;   p1_m = em;
            lkp_valid = v; lkp_mac = m; lkp_src_port = s;
            @(negedge clk);
        end
        lkp_valid = 1'b0;

        // Reset asserted while a learn sits in CMP and a lookup is in flight.
        do_reset();
        for (int i = 0; i < 5; i++) learn({40'h00_0050_0000, 8'(i)}, 4'b0100);
        check("r5_count", entry_count, 5);
        lrn_valid = 1'b1; lrn_mac = 48'h0000_0050_00FF; lrn_port = 4'b0001;
        lkp_valid = 1'b1; lkp_mac = 48'h0000_0050_0001; lkp_src_port = 4'b0001;
        @(posedge clk);
        #1;
        lrn_valid = 1'b0;
        lkp_valid = 1'b0;
        check("cmp_not_ready", lrn_ready, 0);
        rst = 1'b1;
        #1;
        check("cmprst_ready", lrn_ready, 1);
        check("cmprst_count", entry_count, 0);
        check("cmprst_full", table_full, 0);
        check("cmprst_res_valid", res_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        mdl.delete();
        for (int i = 0; i < 4; i++) begin
            check("post_rst_res_valid", res_valid, 0);
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++)
            lookup($sformatf("post_rst_miss%0d", i), {40'h00_0050_0000, 8'(i)}, 4'b0001, 1'b0, 4'b1110);

`ifdef MAC_AGING_EN
        // Aging: AGE_PERIOD=10, AGE_MAX=3 -> expiry 21..30 cycles after the last write.
        do_reset();
        learn(MAC_A, 4'b0010);
        check("age_count1", entry_count, 1);
        repeat (8) @(negedge clk);
        lookup("age_still_hit", MAC_A, 4'b0001, 1'b1, 4'b0010);
        repeat (25) @(negedge clk);
        lookup("age_expired", MAC_A, 4'b0001, 1'b0, 4'b1110);
        check("age_count0", entry_count, 0);
        learn(MAC_A, 4'b0010);
        for (int i = 0; i < 5; i++) begin
            repeat (11) @(negedge clk);
            check("age_refresh_count", entry_count, 1);
            learn(MAC_A, 4'b0010);
        end
        lookup("age_refreshed_hit", MAC_A, 4'b0100, 1'b1, 4'b0010);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
